// File: rtl/lsu_subword_rmw.sv
// Load/store sequencer for a word-wide memory with 1-cycle synchronous read and no byte enables.
// Sub-word stores become read-modify-write; loads are lane-extracted and sign/zero-extended.
module lsu_subword_rmw #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_ISSUE, S_LD_DATA, S_ST_WORD, S_RMW_RD, S_RMW_WR, S_ERR
    } state_t;

    state_t state_q, state_d;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_re_q, mem_we_q, resp_valid_q, resp_err_q;
    logic [DATA_W-1:0] ld_val;

    // Unsigned load variants only exist for loads; alignment follows access size.
    function automatic logic req_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~a[0];
            3'b010:  ok = (a == 2'b00);
            3'b100:  ok = ~we;
            3'b101:  ok = ~we & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [DATA_W-1:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                      input logic [DATA_W-1:0] word);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{(DATA_W-8){b[7]}}, b};
            3'b001:  r = {{(DATA_W-16){h[15]}}, h};
            3'b100:  r = {{(DATA_W-8){1'b0}}, b};
            3'b101:  r = {{(DATA_W-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] lane_merge(input logic [2:0] f3, input logic [1:0] a,
                                                    input logic [DATA_W-1:0] word,
                                                    input logic [DATA_W-1:0] wd);
        logic [DATA_W-1:0] r;
        r = word;
        if (f3 == 3'b000) r[{a, 3'b000} +: 8] = wd[7:0];
        else              r[{a[1], 4'b0000} +: 16] = wd[15:0];
        return r;
    endfunction

    assign req_ready = (state_q == S_IDLE) & ~reset;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (!req_legal(req_we, req_funct3, req_addr[1:0])) state_d = S_ERR;
                    else if (!req_we)                                  state_d = S_LD_ISSUE;
                    else if (req_funct3 == 3'b010)                     state_d = S_ST_WORD;
                    else                                               state_d = S_RMW_RD;
                end
            end
            S_LD_ISSUE: state_d = S_LD_DATA;
            S_RMW_RD:   state_d = S_RMW_WR;
            default:    state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            mem_re_q     <= (state_d == S_LD_ISSUE) || (state_d == S_RMW_RD);
            mem_we_q     <= (state_d == S_ST_WORD) || (state_d == S_RMW_WR);
            resp_valid_q <= (state_d == S_LD_DATA) || (state_d == S_ST_WORD) ||
                            (state_d == S_RMW_WR) || (state_d == S_ERR);
            resp_err_q   <= (state_d == S_ERR);
            if (state_q == S_LD_DATA) rdata_q <= ld_val;
        end
    end

    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Load result is forwarded from memory in the response cycle and held in rdata_q after.
    assign ld_val     = load_extract(f3_q, addr_q[1:0], mem_rdata);
    assign resp_rdata = (state_q == S_LD_DATA) ? ld_val : rdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = (mem_re_q | mem_we_q) ? addr_q[ADDR_W-1:2] : '0;
    assign mem_wdata  = !mem_we_q ? '0 :
                        (state_q == S_RMW_WR) ? lane_merge(f3_q, addr_q[1:0], mem_rdata, wdata_q)
                                              : wdata_q;

endmodule

// File: doc/lsu_subword_rmw.md
# lsu_subword_rmw

Load/store sequencer between the EX/MEM pipeline register and the word-wide data memory. It turns RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on a memory with a 1-cycle synchronous read and no byte enables. Sub-word stores become read-modify-write sequences, and load data is lane-extracted and sign/zero-extended. Misaligned or illegal requests are flagged and never reach memory; the pipeline stalls on `req_ready`.

## Interface
- `ADDR_W`, default 9: byte-address width; the word address is `ADDR_W-2` bits.
- `DATA_W`, default 32: data width; only 32 is supported.

- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — block can accept; transfer when `req_valid & req_ready`.
- `req_we`  in  1  — 1 = store, 0 = load.
- `req_funct3`  in  3  — instruction bits 14:12.
- `req_addr`  in  ADDR_W  — byte address (ALU result LSBs).
- `req_wdata`  in  32  — store data (rs2).
- `resp_valid`  out  1  — 1-cycle completion pulse.
- `resp_err`  out  1  — qualified by `resp_valid`; misaligned or illegal funct3.
- `resp_rdata`  out  32  — load result; held between responses.
- `mem_re`  out  1  — memory read strobe.
- `mem_we`  out  1  — memory write strobe (full word).
- `mem_addr`  out  ADDR_W-2  — word address, `req_addr[ADDR_W-1:2]` latched.
- `mem_wdata`  out  32  — word to write.
- `mem_rdata`  in  32  — read data, valid the cycle after `mem_re`.

## Operation
- Accept: the request is latched (we, funct3, addr, wdata) into internal registers; the inputs are ignored afterwards.
- Legality check at accept:
  - Loads allow funct3 000/001/010/100/101.
  - Stores allow 000/001/010.
  - Halfword requires `addr[0]==0`; word requires `addr[1:0]==00`.
- States: IDLE, LD_ISSUE, LD_DATA, ST_WORD, RMW_RD, RMW_WR, ERR.
- IDLE → ERR (illegal), → LD_ISSUE (load), → ST_WORD (SW), → RMW_RD (SB/SH).
- LD_ISSUE: `mem_re=1` → LD_DATA.
- LD_DATA: select the lane by `addr[1:0]`.
  - Byte = `mem_rdata[8*addr[1:0]+:8]`; half = `mem_rdata[16*addr[1]+:16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Register the result into `resp_rdata`, pulse `resp_valid`, then → IDLE.
- ST_WORD: `mem_we=1`, `mem_wdata=wdata`, `resp_valid=1` → IDLE.
- RMW_RD: `mem_re=1` → RMW_WR.
- RMW_WR: `mem_we=1`, `mem_wdata` = `mem_rdata` with the selected lane replaced by `wdata[7:0]` (SB) or `wdata[15:0]` (SH). `resp_valid=1` → IDLE.
- ERR: `resp_valid=1`, `resp_err=1`; no `mem_re`/`mem_we` at any point → IDLE.
- `resp_err=0` on every non-ERR response. Stores and errors leave `resp_rdata` unchanged.
- `mem_re` and `mem_we` are never asserted together. `mem_addr` and `mem_wdata` are 0 whenever neither strobe is high.

## Timing
- `req_ready = (state==IDLE) & ~reset`. Exactly one request is in flight.
- Latency from the accept edge to the `resp_valid` cycle:
  - ERR and SW: 1 cycle.
  - Loads and SB/SH: 2 cycles.
- A new request can be accepted in the cycle after `resp_valid`. Peak throughput is one SW every 2 cycles.
- `resp_valid` is high for exactly one cycle per accepted request.
- The load `resp_rdata` value is visible in the same cycle as `resp_valid`, driven combinationally from `mem_rdata` and registered on that edge for holding.
- Reset, asynchronous, any state:
  - state=IDLE, `req_ready=0`; all other outputs are 0, including `resp_rdata`.
  - An RMW interrupted in RMW_RD never writes.
  - `mem_we` drops immediately when reset asserts.
- The first accept is possible on the first rising edge after reset deasserts.
- `req_valid` high while `req_ready=0` is not a transfer; the requester holds it.

## Test plan
- Memory word 5 = 0x8765_43A1. LB at addr 0x14 → after 2 cycles `resp_rdata`=0xFFFF_FFA1. LBU at addr 0x17 → 0x0000_0087.
- Word 5 = 0x8765_43A1. LH at 0x16 → 0xFFFF_8765. LHU at 0x16 → 0x0000_8765.
- Word 2 = 0x1122_3344. SB 0xAB at addr 0x09 → one `mem_re`, then `mem_we` with data 0x1122_AB44. SH 0xBEEF at 0x0A → 0xBEEF_AB44.
- Misaligned cases: LW at 0x06, SH at 0x03, load funct3=011 → `resp_err=1` one cycle after accept; zero memory strobes; `resp_rdata` unchanged.
- Back-to-back: SW 0xDEAD_BEEF at 0x10, then LW at 0x10 accepted the cycle after the SW response → `resp_rdata`=0xDEAD_BEEF; `req_ready` low during busy cycles.
- Reset asserted in RMW_RD of an SB → no `mem_we` ever; memory word unchanged; all outputs 0; `req_ready`=1 one cycle after release.
